req_arbiter8: RTL and testbench
===============================

Name: req_arbiter8

Overview:
Sequential arbiter that shares one downstream resource among 8 requesters. It uses the team's priority-encode convention: highest index wins, with a one-hot vector and a 3-bit index out. It holds a grant until the owner finishes, releases it or hits a hold-time cap, and inserts one idle cycle between owners. It sits between request sources (keys, peripherals) and a shared single-port unit.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held before forced release (2..255)
CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  arbiter enable; 0 blocks new grants and releases any current grant
req  input  8  request vector, bit i = requester i
done  input  1  owner finished; single-cycle pulse, sampled only in GRANT
gnt  output  8  one-hot grant, registered; all-zero when no owner
gnt_idx  output  3  index of current owner; 0 when gnt_valid=0
gnt_valid  output  1  1 while a grant is held (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD
busy  output  1  1 in GRANT or COOLDOWN

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, busy=0, hold_cnt=0, last_idx=0.
- All outputs are registered; none is combinational from inputs.
- States: IDLE, GRANT, COOLDOWN.
- IDLE: at a rising edge with en=1 and req!=0, choose the winner k, then state=GRANT, gnt=1<<k, gnt_idx=k, hold_cnt=0, last_idx=k. Latency: req sampled at edge t, gnt visible after edge t (1 cycle). en=0 or req=0 -> stay IDLE.
- Fixed priority selects the highest set index: req=8'b0010_0110 -> k=5.
- GRANT: each edge, evaluate in this order:
  1. en=0 -> COOLDOWN, no timeout.
  2. done=1 -> COOLDOWN, no timeout (done beats a same-cycle cap).
  3. req[gnt_idx]=0 -> COOLDOWN (owner withdrew).
  4. hold_cnt==MAX_HOLD-1 -> COOLDOWN with timeout=1 for exactly that next cycle.
  5. Otherwise stay in GRANT, hold_cnt+1.
- A grant therefore lasts at most MAX_HOLD cycles.
- Requests from other indices during GRANT are ignored; there is no pre-emption, even by a higher index.
- COOLDOWN: gnt=0, gnt_valid=0, gnt_idx=0, busy=1, exactly one cycle, then IDLE unconditionally. The earliest re-grant appears 2 cycles after release.
- gnt changes only on state transitions and is never multi-hot.
- Reset mid-GRANT: gnt drops immediately (async) and the block restarts in IDLE.
- done outside GRANT is ignored.
- hold_cnt saturates; it never wraps.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: rotating priority. After a grant to k, the search order is k-1, k-2, ..., 0, 7, ..., k, so the last owner becomes lowest priority. At reset last_idx=0, giving order 7..0, identical to fixed priority until the first grant. Only grants update last_idx.
- Undefined: fixed priority, index 7 highest, 0 lowest. last_idx is unused and may be optimised away.

Test Plan:
- Reset -> all outputs 0. Pulse rst_n low mid-GRANT -> gnt=0 within the same cycle; state=IDLE after release.
- en=1, req=8'h26 held -> the edge after req: gnt=8'h20, gnt_idx=5, gnt_valid=1. done pulse -> next cycle gnt=0, busy=1; the following cycle busy=0, then re-grant to 5.
- req=8'h01 held, no done, MAX_HOLD=16 -> gnt=8'h01 for exactly 16 cycles, timeout=1 for 1 cycle with gnt=0. Repeat with done asserted on cycle 16 -> timeout stays 0.
- Granted to idx 2 while req[7] rises -> gnt stays 8'h04 until req[2] drops. Next grant goes to 7 after one COOLDOWN cycle.
- en dropped during GRANT -> release next edge, timeout=0. req=8'hFF with en=0 -> gnt never asserts.
- ARB_ROUND_ROBIN_EN defined, req=8'hFF held, done pulsed each grant -> grant order 7,6,5,4,3,2,1,0,7. Without the macro -> 7 every time.

Source files
------------

// File: rtl/req_arbiter8_if.sv
// req_arbiter8_if: request/grant bundle between requesters and the 8-way arbiter.
interface req_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       busy;
  modport master (output en, req, done, input gnt, gnt_idx, gnt_valid, timeout, busy);
  modport slave  (input en, req, done, output gnt, gnt_idx, gnt_valid, timeout, busy);
endinterface

// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-way hold-until-release arbiter, highest index wins, one idle cycle between owners.
// Define ARB_ROUND_ROBIN_EN for rotating priority (last owner becomes lowest priority).
module req_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           rst_n,
  req_arbiter8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, cnt_nx;
  logic [7:0]       gnt_q, gnt_nx;
  logic [2:0]       idx_q, idx_nx, win;
  logic             valid_q, to_q, busy_q, to_nx, release_c;
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0]       last_idx, last_nx;
  // Walk from last_idx-8 up to last_idx-1 so the nearest lower index is assigned last and wins.
  always_comb begin
    win = '0;
    for (int i = 8; i >= 1; i--)
      if (bus.req[last_idx - 3'(i)]) win = last_idx - 3'(i);
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < 8; i++)
      if (bus.req[i]) win = 3'(i);
  end
`endif
  // Release priority: en, done, withdrawal, then the hold cap; timeout only when the cap alone fires.
  assign release_c = !bus.en || bus.done || !bus.req[idx_q] || hold_cnt == CNT_W'(MAX_HOLD - 1);
  always_comb begin
    state_nx = state;
    gnt_nx   = '0;
    idx_nx   = '0;
    to_nx    = 1'b0;
    cnt_nx   = hold_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    last_nx  = last_idx;
`endif
    case (state)
      IDLE: if (bus.en && |bus.req) begin
        state_nx = GRANT;
        gnt_nx   = 8'(1) << win;
        idx_nx   = win;
        cnt_nx   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_nx  = win;
`endif
      end
      GRANT: if (release_c) begin
        state_nx = COOLDOWN;
        to_nx    = bus.en && !bus.done && bus.req[idx_q];
      end else begin
        gnt_nx = gnt_q;
        idx_nx = idx_q;
        cnt_nx = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_idx <= '0;
`endif
    end else begin
      state    <= state_nx;
      gnt_q    <= gnt_nx;
      idx_q    <= idx_nx;
      valid_q  <= state_nx == GRANT;
      to_q     <= to_nx;
      busy_q   <= state_nx != IDLE;
      hold_cnt <= cnt_nx;
`ifdef ARB_ROUND_ROBIN_EN
      last_idx <= last_nx;
`endif
    end
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: checks req_arbiter8 against an owner/cooldown model every cycle plus literal spot checks.
module tb_req_arbiter8;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0, rst_n;
  int compared = 0, mismatched = 0;
  req_arbiter8_if bus();
  req_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // Model: who owns the resource, how many cycles it has been visible, and whether we are in the idle gap.
  int owner = -1, held = 0, last = 0;
  bit cool = 0, to_e = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; held = 0; last = 0; cool = 0; to_e = 0;
    end else begin
      to_e = 0;
      if (owner >= 0) begin
        held++;
        if (!bus.en || bus.done || !bus.req[owner]) begin owner = -1; cool = 1; end
        else if (held == MAX_HOLD) begin owner = -1; cool = 1; to_e = 1; end
      end else if (cool) cool = 0;
      else if (bus.en && bus.req != 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        for (int d = 1; d <= 8; d++)
          if (owner < 0 && bus.req[(last - d + 8) % 8]) owner = (last - d + 8) % 8;
`else
        for (int c = 7; c >= 0; c--)
          if (owner < 0 && bus.req[c]) owner = c;
`endif
        held = 0; last = owner;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    logic [2:0] ei;
    eg = owner >= 0 ? 8'(1) << owner : 8'h00;
    ei = owner >= 0 ? 3'(owner) : 3'd0;
    compared++;
    if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, bus.busy} !==
        {eg, ei, owner >= 0, to_e, owner >= 0 || cool}) begin
      mismatched++;
      $display("FAIL cycle t=%0t: got gnt=%h idx=%0d valid=%b to=%b busy=%b, want gnt=%h idx=%0d valid=%b to=%b busy=%b",
               $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, bus.busy,
               eg, ei, owner >= 0, to_e, owner >= 0 || cool);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, to_cnt, any, w;
    rst_n = 0; bus.en = 0; bus.req = 0; bus.done = 0;
    cyc(2);
    chk("reset_outputs", 32'({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, bus.busy}), 0);
    rst_n = 1; cyc(1);
    bus.en = 1; bus.req = 8'h26; cyc(1);
    chk("grant_26_gnt", bus.gnt, 8'h20);
    chk("grant_26_idx", bus.gnt_idx, 5);
    chk("grant_26_valid", bus.gnt_valid, 1);
    bus.done = 1; cyc(1); bus.done = 0;
    chk("done_release_gnt", bus.gnt, 0);
    chk("done_release_busy", bus.busy, 1);
    cyc(1);
    chk("cooldown_over_busy", bus.busy, 0);
    cyc(1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("regrant_26", bus.gnt, 8'h04);
`else
    chk("regrant_26", bus.gnt, 8'h20);
`endif
    bus.req = 0; cyc(3);
    bus.req = 8'h01; cnt = 0; to_cnt = 0;
    repeat (18) begin
      cyc(1);
      cnt += int'(bus.gnt == 8'h01);
      to_cnt += int'(bus.timeout);
      if (bus.timeout) chk("timeout_gnt_zero", bus.gnt, 0);
    end
    chk("hold_cycles", cnt, MAX_HOLD);
    chk("timeout_pulses", to_cnt, 1);
    cyc(1);
    chk("regrant_after_timeout", bus.gnt, 8'h01);
    cyc(MAX_HOLD - 1);
    chk("still_held_cycle16", bus.gnt, 8'h01);
    bus.done = 1; cyc(1); bus.done = 0;
    chk("done_beats_cap_to", bus.timeout, 0);
    chk("done_beats_cap_gnt", bus.gnt, 0);
    bus.req = 0; cyc(3);
    bus.req = 8'h04; cyc(1);
    chk("grant_idx2", bus.gnt, 8'h04);
    bus.req = 8'h84; cyc(3);
    chk("no_preempt", bus.gnt, 8'h04);
    bus.req = 8'h80; cyc(1);
    chk("withdraw_gnt", bus.gnt, 0);
    chk("withdraw_busy", bus.busy, 1);
    cyc(1);
    chk("gap_gnt", bus.gnt, 0);
    cyc(1);
    chk("grant_idx7", bus.gnt, 8'h80);
    chk("grant_idx7_idx", bus.gnt_idx, 7);
    bus.req = 0; cyc(3);
    bus.req = 8'h10; cyc(1);
    chk("grant_idx4", bus.gnt, 8'h10);
    bus.en = 0; cyc(1);
    chk("en_drop_gnt", bus.gnt, 0);
    chk("en_drop_to", bus.timeout, 0);
    bus.req = 8'hFF; any = 0;
    repeat (20) begin cyc(1); any |= int'(bus.gnt != 0); end
    chk("en0_no_grant", any, 0);
    bus.en = 1; bus.req = 8'h08; cyc(1);
    chk("pre_reset_gnt", bus.gnt, 8'h08);
    #2 rst_n = 0;
    #1 chk("async_reset_gnt", bus.gnt, 0);
    chk("async_reset_valid", bus.gnt_valid, 0);
    bus.req = 0; cyc(1); rst_n = 1; cyc(1);
    chk("after_reset_idle", 32'({bus.gnt, bus.busy}), 0);
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      w = 0;
      while (!bus.gnt_valid && w < 6) begin cyc(1); w++; end
      chk("rotation_granted", bus.gnt_valid, 1);
`ifdef ARB_ROUND_ROBIN_EN
      chk("rotation_idx", bus.gnt_idx, (15 - g) % 8);
`else
      chk("rotation_idx", bus.gnt_idx, 7);
`endif
      bus.done = 1; cyc(1); bus.done = 0;
    end
    bus.req = 0; cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
